// File: rtl/wb_port_arbiter_if.sv
// Writeback port arbiter bus: pipeline/LLU write requests, scoreboard
// issue/decode queries and the register-file write port.
interface wb_port_arbiter_if;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        llu_valid;
   logic        llu_ready;
   logic [4:0]  llu_rd;
   logic [31:0] llu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        dec_valid;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [4:0]  dec_rd;
   logic        dec_stall;
   logic        pipe_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   modport master (
      output wb_valid, wb_rd, wb_data,
      output llu_valid, llu_rd, llu_data,
      output issue_valid, issue_rd,
      output dec_valid, dec_rs1, dec_rs2, dec_rd,
      input  llu_ready, dec_stall, pipe_stall,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      input  llu_valid, llu_rd, llu_data,
      input  issue_valid, issue_rd,
      input  dec_valid, dec_rs1, dec_rs2, dec_rd,
      output llu_ready, dec_stall, pipe_stall,
      output rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline vs long-latency unit, with
// a starvation limit and a busy scoreboard driving the decode stall.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              reset,
   wb_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [31:0] busy, busy_n;
   logic        rdy;
   logic        grant_wb;
   logic        accept;
   logic        win;
   logic [4:0]  win_rd;
   logic [31:0] win_data;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rdy      = 1'b0;
      grant_wb = 1'b0;
      bus.pipe_stall = 1'b0;
      unique case (state)
         IDLE: begin
            rdy      = !bus.wb_valid;
            grant_wb = bus.wb_valid;
            if (bus.wb_valid && bus.llu_valid) begin
               cnt_n   = 4'd1;
               state_n = (LIMIT == 4'd1) ? FORCE : WAIT;
            end
         end
         WAIT: begin
            rdy      = !bus.wb_valid;
            grant_wb = bus.wb_valid;
            if (bus.wb_valid && bus.llu_valid) begin
               cnt_n = cnt + 4'd1;
               if (cnt + 4'd1 >= LIMIT)
                  state_n = FORCE;
            end else begin
               cnt_n   = 4'd0;
               state_n = IDLE;
            end
         end
         FORCE: begin
            // pipeline is frozen; its request is re-presented next cycle
            bus.pipe_stall = 1'b1;
            rdy      = 1'b1;
            cnt_n    = 4'd0;
            state_n  = IDLE;
         end
         default: begin
            cnt_n   = 4'd0;
            state_n = IDLE;
         end
      endcase
   end

   assign bus.llu_ready = reset & rdy;
   assign accept = bus.llu_valid & bus.llu_ready;
   assign win    = grant_wb | accept;
   assign win_rd   = grant_wb ? bus.wb_rd : bus.llu_rd;
   assign win_data = grant_wb ? bus.wb_data : bus.llu_data;

   always_comb begin
      busy_n = busy;
      if (accept)
         busy_n[bus.llu_rd] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 5'd0)
         busy_n[bus.issue_rd] = 1'b1;
      busy_n[0] = 1'b0;
   end

   assign bus.dec_stall = bus.pipe_stall
      | (bus.dec_valid & (busy[bus.dec_rs1]
                        | busy[bus.dec_rs2]
                        | busy[bus.dec_rd]))
      | (bus.issue_valid & busy[bus.issue_rd]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         busy  <= 32'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rf_we    <= 1'b0;
         bus.rf_waddr <= 5'd0;
         bus.rf_wdata <= 32'd0;
      end else begin
         bus.rf_we <= win && (win_rd != 5'd0);
         if (win) begin
            bus.rf_waddr <= win_rd;
            bus.rf_wdata <= win_data;
         end
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter: per-cycle stimulus table
// plus hand-written reset-during-WAIT sequence.
module tb_wb_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   wb_port_arbiter_if bus();

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wbv;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic        iv;
      logic [4:0]  ird;
      logic        dv;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        e_lr;
      logic        e_ps;
      logic        e_ds;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic wbv, input logic [4:0] wrd, input logic [31:0] wdat,
      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
      input logic iv, input logic [4:0] ird,
      input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd,
      input logic lr, input logic ps, input logic ds,
      input logic we, input logic [4:0] wa, input logic [31:0] wd);
      vec_t v;
      v.wbv = wbv; v.wrd = wrd; v.wdat = wdat;
      v.lv = lv; v.lrd = lrd; v.ldat = ldat;
      v.iv = iv; v.ird = ird;
      v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
      v.e_lr = lr; v.e_ps = ps; v.e_ds = ds;
      v.e_we = we; v.e_wa = wa; v.e_wd = wd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.wb_valid    = v.wbv;
      bus.wb_rd       = v.wrd;
      bus.wb_data     = v.wdat;
      bus.llu_valid   = v.lv;
      bus.llu_rd      = v.lrd;
      bus.llu_data    = v.ldat;
      bus.issue_valid = v.iv;
      bus.issue_rd    = v.ird;
      bus.dec_valid   = v.dv;
      bus.dec_rs1     = v.rs1;
      bus.dec_rs2     = v.rs2;
      bus.dec_rd      = v.rd;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      string t;
      t = $sformatf("v%0d", i);
      chk({t, " llu_ready"}, 32'(bus.llu_ready), 32'(v.e_lr));
      chk({t, " pipe_stall"}, 32'(bus.pipe_stall), 32'(v.e_ps));
      chk({t, " dec_stall"}, 32'(bus.dec_stall), 32'(v.e_ds));
      chk({t, " rf_we"}, 32'(bus.rf_we), 32'(v.e_we));
      if (v.e_we) begin
         chk({t, " rf_waddr"}, 32'(bus.rf_waddr), 32'(v.e_wa));
         chk({t, " rf_wdata"}, bus.rf_wdata, v.e_wd);
      end
   endtask

   vec_t idle;

   initial begin
      idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0);
      // lone pipeline write
      tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 1,5,32'hDEADBEEF));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      // x0 suppression
      tbl.push_back(mk(0,0,0, 1,0,32'h1234, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      // conflict
      tbl.push_back(mk(1,2,32'h22, 1,7,32'h77, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 1,7,32'h77, 0,0, 0,0,0,0, 1,0,0, 1,2,32'h22));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 1,7,32'h77));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      // starvation
      tbl.push_back(mk(1,1,32'h100, 1,8,32'h800, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      tbl.push_back(mk(1,2,32'h101, 1,8,32'h800, 0,0, 0,0,0,0, 0,0,0, 1,1,32'h100));
      tbl.push_back(mk(1,3,32'h102, 1,8,32'h800, 0,0, 0,0,0,0, 0,0,0, 1,2,32'h101));
      tbl.push_back(mk(1,4,32'h103, 1,8,32'h800, 0,0, 0,0,0,0, 0,0,0, 1,3,32'h102));
      tbl.push_back(mk(1,5,32'h104, 1,8,32'h800, 0,0, 0,0,0,0, 1,1,1, 1,4,32'h103));
      tbl.push_back(mk(1,5,32'h104, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 1,8,32'h800));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 1,5,32'h104));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      // scoreboard
      tbl.push_back(mk(0,0,0, 0,0,0, 1,9, 0,0,0,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1,9,0,0, 1,0,1, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 1,0, 1,9,0,0, 1,0,1, 0,0,0));
      tbl.push_back(mk(0,0,0, 1,9,32'h999, 0,0, 1,9,0,0, 1,0,1, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1,9,0,0, 1,0,0, 1,9,32'h999));
      // same-cycle set and clear
      tbl.push_back(mk(0,0,0, 0,0,0, 1,9, 0,0,0,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 1,9,32'hAAA, 1,9, 0,0,0,0, 1,0,1, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,9,0, 1,0,1, 1,9,32'hAAA));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,0,9, 1,0,1, 0,0,0));
      tbl.push_back(mk(0,0,0, 1,9,32'hBBB, 0,0, 0,0,0,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,0,9, 1,0,0, 1,9,32'hBBB));

      // reset state
      drive(idle);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst llu_ready", 32'(bus.llu_ready), 32'd0);
      chk("rst rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst rf_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst rf_wdata", bus.rf_wdata, 32'd0);
      chk("rst pipe_stall", 32'(bus.pipe_stall), 32'd0);
      chk("rst dec_stall", 32'(bus.dec_stall), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         check_vec(i, tbl[i]);
      end

      // reset asserted while in WAIT with busy[3] set
      @(negedge clk);
      drive(mk(1,4,32'h44, 1,3,32'h33, 1,3, 0,0,0,0, 0,0,0, 0,0,0));
      #1;
      chk("mw enter llu_ready", 32'(bus.llu_ready), 32'd0);
      @(negedge clk);
      drive(mk(1,6,32'h66, 1,3,32'h33, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      #1;
      chk("mw wait rf_we", 32'(bus.rf_we), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      drive(mk(0,0,0, 1,3,32'h33, 0,0, 1,3,0,0, 0,0,0, 0,0,0));
      #1;
      chk("mw rst rf_we", 32'(bus.rf_we), 32'd0);
      chk("mw rst rf_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("mw rst rf_wdata", bus.rf_wdata, 32'd0);
      chk("mw rst llu_ready", 32'(bus.llu_ready), 32'd0);
      chk("mw rst pipe_stall", 32'(bus.pipe_stall), 32'd0);
      chk("mw rst dec_stall", 32'(bus.dec_stall), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(mk(0,0,0, 0,0,0, 0,0, 1,3,0,0, 0,0,0, 0,0,0));
      #1;
      chk("mw post dec_stall", 32'(bus.dec_stall), 32'd0);
      chk("mw post rf_we", 32'(bus.rf_we), 32'd0);
      chk("mw post llu_ready", 32'(bus.llu_ready), 32'd1);

      // starvation count restarts from IDLE after reset
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(mk(1,5'(10 + k),32'(k), 1,11,32'h55, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
         #1;
         chk($sformatf("mw starve%0d pipe_stall", k),
             32'(bus.pipe_stall), (k == 4) ? 32'd1 : 32'd0);
         chk($sformatf("mw starve%0d llu_ready", k),
             32'(bus.llu_ready), (k == 4) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      drive(idle);
      #1;
      chk("mw final rf_waddr", 32'(bus.rf_waddr), 32'd11);
      chk("mw final rf_wdata", bus.rf_wdata, 32'h55);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Controller for the register-file write port fed by the writeback stage. Arbitrates the single write port between the in-order pipeline writeback and a long-latency unit (LLU, e.g. multiply/divide), tracks destination registers of in-flight LLU operations in a 32-entry scoreboard, and raises a decode stall on RAW/WAW hazards. The LLU can be starved by the pipeline for at most STARVE_LIMIT cycles, after which the pipeline is frozen for one cycle.

## Interface
- STARVE_LIMIT, 4: consecutive blocked LLU cycles before a forced grant; legal 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  one clock; reset is asynchronous and active-low; all state clears while reset==0.
- wb_valid  in  1  pipeline writeback request; cannot be back-pressured except via pipe_stall.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- llu_valid  in  1  LLU result valid; held with rd/data stable until accepted.
- llu_ready  out  1  LLU result accepted this cycle (llu_valid & llu_ready).
- llu_rd  in  5  LLU destination register.
- llu_data  in  32  LLU write data.
- issue_valid  in  1  decode issues an LLU op this cycle.
- issue_rd  in  5  destination of the issued LLU op.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode operand/destination registers.
- dec_stall  out  1  decode must hold.
- pipe_stall  out  1  freeze whole pipeline (WB stage re-presents its request next cycle).
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.

## Operation
- FSM states IDLE, WAIT, FORCE; reset state IDLE, starve counter 0.
- IDLE: pipeline has priority; llu_ready = !wb_valid. llu_valid & wb_valid -> WAIT, counter=1.
- WAIT: llu_ready = !wb_valid; each blocked cycle counter+1. Accepted -> IDLE, counter=0. Counter reaches STARVE_LIMIT while blocked -> FORCE.
- FORCE (one cycle): pipe_stall=1, llu_ready=1, wb_valid ignored (no pipeline write). Next state IDLE, counter=0. If llu_valid==0 in FORCE: no write, still return to IDLE.
- Write port: winner's rd/data registered onto rf_waddr/rf_wdata; rf_we=1 only if winner's rd!=0. rd==0 handshake still completes (llu_ready asserts), no write.
- Scoreboard busy[31:0]: issue_valid with issue_rd!=0 sets busy[issue_rd]; LLU acceptance clears busy[llu_rd]. busy[0] always 0. Set and clear of the same index in one cycle: set wins.
- dec_stall = pipe_stall | (dec_valid & (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd])) | (issue_valid & busy[issue_rd]).
- Pipeline writes never clear busy bits; WAW against busy registers is prevented by dec_stall.

## Timing
- Grant is combinational in cycle N; rf_we/rf_waddr/rf_wdata valid in cycle N+1 for exactly one cycle unless another grant follows.
- Busy clear registered at the N->N+1 edge together with the write; dec_stall drops in N+1 while the write occurs; register file is write-first so decode reads the new value in N+1.
- Busy set on issue visible from cycle N+1.
- pipe_stall, dec_stall, llu_ready are combinational from state, counter, busy and inputs.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, pipe_stall=0, dec_stall=0, llu_ready=0 while reset==0.
- Reset asserted mid-WAIT/FORCE: state to IDLE, pending LLU result not written, busy cleared; LLU must re-present after reset.
- Worst-case LLU latency from llu_valid to acceptance: STARVE_LIMIT+1 cycles.

## Test plan
- Lone pipeline write: wb_valid, rd=5, data=0xDEADBEEF in cycle 0 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 1 only.
- x0 suppression: llu_valid, llu_rd=0, data=0x1234 -> llu_ready=1 same cycle, rf_we stays 0.
- Conflict: wb_valid and llu_valid (rd=7) in cycle 0, wb_valid low in cycle 1 -> pipeline written cycle 1, LLU accepted cycle 1, rf_waddr=7 in cycle 2, state back to IDLE.
- Starvation: STARVE_LIMIT=4, wb_valid held high and llu_valid high from cycle 0 -> FORCE in cycle 4 with pipe_stall=1, llu_ready=1, no pipeline write that cycle; LLU write visible cycle 5.
- Scoreboard: issue_rd=9 cycle 0; dec_rs1=9 cycle 1 -> dec_stall=1; LLU accepts rd=9 cycle 3 -> rf write cycle 4, dec_stall=0 from cycle 4; same-cycle set+clear of rd=9 leaves busy[9]=1.
- Reset mid-WAIT: reset low for 1 cycle during WAIT with busy[3]=1 -> all outputs 0, busy=0, state IDLE after release.
